// File: rtl/freq_meas_ctrl_if.sv
// Result channel from the frequency-meter sequencer to the display/UART side.
//
// Handshake: the master raises res_valid with res_freq/res_range/res_err and
// holds all three stable until it samples res_valid & res_ready high on a
// clock edge. That edge completes the transfer. The slave may drive res_ready
// at any time, and a ready seen without valid has no effect.
//
// Signals:
//   res_freq   [31:0] scaled frequency in Hz, saturating
//   res_range  [1:0]  gate range that produced res_freq
//   res_err           1 = meter never answered, res_freq is 0
//   res_valid         result available (master -> slave)
//   res_ready         result accepted  (slave -> master)
interface freq_meas_ctrl_if;
  logic [31:0] res_freq;
  logic [1:0]  res_range;
  logic        res_err;
  logic        res_valid;
  logic        res_ready;

  modport master (
    output res_freq,
    output res_range,
    output res_err,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_freq,
    input  res_range,
    input  res_err,
    input  res_valid,
    output res_ready
  );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Sequencer for the 10 MHz frequency-meter datapath.
// Generates the two gate_clk edges that bound each counting window, selects
// the gate length (fixed or auto-ranged), captures the meter count, scales it
// to Hz and offers the result on the res interface.
//
// Ports:
//   clk_10m      10 MHz system clock
//   rst_n        synchronous reset, active low
//   start        1-cycle pulse, begins a measurement when idle
//   cont_mode    1 = re-arm after every accepted result
//   range_mode   0/1/2 fixed range, 3 auto-range
//   meter_freq   raw count from the meter
//   meter_valid  meter result-valid level
//   gate_clk     gate edges to the meter
//   busy         high in every state except IDLE
//   dbg_state    current FSM state encoding
//   res          result channel (master side)
module freq_meas_ctrl #(
  parameter int GATE_CYC0 = 10_000_000,
  parameter int GATE_CYC1 = 1_000_000,
  parameter int GATE_CYC2 = 100_000,
  parameter int GATE_HI   = 16,
  parameter int RANGE_UP  = 20_000,
  parameter int RANGE_DN  = 1_000,
  parameter int TIMEOUT   = 65_536
) (
  input  logic             clk_10m,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont_mode,
  input  logic [1:0]       range_mode,
  input  logic [31:0]      meter_freq,
  input  logic             meter_valid,
  output logic             gate_clk,
  output logic             busy,
  output logic [2:0]       dbg_state,
  freq_meas_ctrl_if.master res
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FREE, S_EDGE_A, S_GATE, S_EDGE_B, S_WAIT_RES, S_PUBLISH
  } state_t;

  // Terminal counts; the gate counter value at the last cycle of each phase.
  localparam logic [23:0] GATE_END0 = 24'(GATE_CYC0 - 1);
  localparam logic [23:0] GATE_END1 = 24'(GATE_CYC1 - 1);
  localparam logic [23:0] GATE_END2 = 24'(GATE_CYC2 - 1);
  localparam logic [23:0] HI_END_G  = 24'(GATE_HI - 1);
  localparam logic [16:0] HI_END_T  = 17'(GATE_HI - 1);
  localparam logic [16:0] TO_END    = 17'(TIMEOUT - 1);
  localparam logic [31:0] UP_W      = 32'(RANGE_UP);
  localparam logic [31:0] DN_W      = 32'(RANGE_DN);

  state_t      state_q, state_d;
  logic [2:0]  free_cnt_q, free_cnt_d;
  logic [23:0] gate_cnt_q, gate_cnt_d;
  logic [16:0] to_cnt_q, to_cnt_d;
  logic [1:0]  cur_range_q, cur_range_d;
  logic        mv_q;
  logic [31:0] raw_q, raw_d;
  logic [31:0] res_freq_q, res_freq_d;
  logic [1:0]  res_range_q, res_range_d;
  logic        res_err_q, res_err_d;

  logic [23:0] gate_end;
  logic [39:0] scaled;
  logic [31:0] sat_freq;
  logic        mv_rise;
  logic [23:0] gate_cnt_inc;
  logic [16:0] to_cnt_inc;

  always_comb begin
    case (cur_range_q)
      2'd0:    gate_end = GATE_END0;
      2'd1:    gate_end = GATE_END1;
      default: gate_end = GATE_END2;
    endcase

    case (cur_range_q)
      2'd0:    scaled = {8'd0, meter_freq};
      2'd1:    scaled = {8'd0, meter_freq} * 40'd10;
      default: scaled = {8'd0, meter_freq} * 40'd100;
    endcase
    sat_freq = (|scaled[39:32]) ? 32'hFFFF_FFFF : scaled[31:0];

    // Only a fresh 0->1 transition counts; a level left over from the
    // previous result must not be mistaken for a new one.
    mv_rise = meter_valid & ~mv_q;

    // Counters hold at all-ones instead of wrapping.
    gate_cnt_inc = (&gate_cnt_q) ? gate_cnt_q : gate_cnt_q + 24'd1;
    to_cnt_inc   = (&to_cnt_q)   ? to_cnt_q   : to_cnt_q + 17'd1;
  end

  always_comb begin
    state_d     = state_q;
    free_cnt_d  = free_cnt_q;
    gate_cnt_d  = gate_cnt_q;
    to_cnt_d    = to_cnt_q;
    cur_range_d = cur_range_q;
    raw_d       = raw_q;
    res_freq_d  = res_freq_q;
    res_range_d = res_range_q;
    res_err_d   = res_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WAIT_FREE;
          free_cnt_d = 3'd0;
          if (range_mode != 2'd3) cur_range_d = range_mode;
        end
      end
      S_WAIT_FREE: begin
        // Eight quiet cycles in a row cover the meter's post-result lockout.
        if (meter_valid) begin
          free_cnt_d = 3'd0;
        end else if (free_cnt_q == 3'd7) begin
          state_d    = S_EDGE_A;
          gate_cnt_d = 24'd0;
        end else begin
          free_cnt_d = free_cnt_q + 3'd1;
        end
      end
      S_EDGE_A: begin
        gate_cnt_d = gate_cnt_inc;
        if (gate_cnt_q == HI_END_G) state_d = S_GATE;
      end
      S_GATE: begin
        gate_cnt_d = gate_cnt_inc;
        if (gate_cnt_q == gate_end) begin
          state_d  = S_EDGE_B;
          to_cnt_d = 17'd0;
        end
      end
      S_EDGE_B: begin
        to_cnt_d = to_cnt_inc;
        if (to_cnt_q == HI_END_T) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        to_cnt_d = to_cnt_inc;
        if (mv_rise) begin
          state_d     = S_PUBLISH;
          raw_d       = meter_freq;
          res_freq_d  = sat_freq;
          res_range_d = cur_range_q;
          res_err_d   = 1'b0;
        end else if (to_cnt_q == TO_END) begin
          // PUBLISH is entered exactly TIMEOUT cycles after the B edge.
          state_d     = S_PUBLISH;
          res_freq_d  = 32'd0;
          res_range_d = cur_range_q;
          res_err_d   = 1'b1;
        end
      end
      S_PUBLISH: begin
        if (res.res_ready) begin
          if (range_mode != 2'd3) begin
            cur_range_d = range_mode;
          end else if (!res_err_q) begin
            if (raw_q >= UP_W && cur_range_q < 2'd2)
              cur_range_d = cur_range_q + 2'd1;
            else if (raw_q < DN_W && cur_range_q != 2'd0)
              cur_range_d = cur_range_q - 2'd1;
          end
          free_cnt_d = 3'd0;
          state_d    = cont_mode ? S_WAIT_FREE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_10m) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      free_cnt_q  <= 3'd0;
      gate_cnt_q  <= 24'd0;
      to_cnt_q    <= 17'd0;
      cur_range_q <= 2'd0;
      mv_q        <= 1'b0;
      raw_q       <= 32'd0;
      res_freq_q  <= 32'd0;
      res_range_q <= 2'd0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      free_cnt_q  <= free_cnt_d;
      gate_cnt_q  <= gate_cnt_d;
      to_cnt_q    <= to_cnt_d;
      cur_range_q <= cur_range_d;
      mv_q        <= meter_valid;
      raw_q       <= raw_d;
      res_freq_q  <= res_freq_d;
      res_range_q <= res_range_d;
      res_err_q   <= res_err_d;
    end
  end

  assign gate_clk      = (state_q == S_EDGE_A) || (state_q == S_EDGE_B);
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;
  assign res.res_valid = (state_q == S_PUBLISH);
  assign res.res_freq  = res_freq_q;
  assign res.res_range = res_range_q;
  assign res.res_err   = res_err_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
`timescale 1ns/1ps
module tb_freq_meas_ctrl;
  localparam int G0 = 1200, G1 = 600, G2 = 300, GHI = 16;
  localparam int RUP = 20000, RDN = 1000, TMO = 700;

  logic        clk = 1'b0;
  logic        rst_n, start, cont_mode, meter_valid;
  logic [1:0]  range_mode;
  logic [31:0] meter_freq;
  logic        gate_clk, busy;
  logic [2:0]  dbg_state;

  freq_meas_ctrl_if r_if();

  freq_meas_ctrl #(
    .GATE_CYC0(G0), .GATE_CYC1(G1), .GATE_CYC2(G2), .GATE_HI(GHI),
    .RANGE_UP(RUP), .RANGE_DN(RDN), .TIMEOUT(TMO)
  ) dut (
    .clk_10m(clk), .rst_n(rst_n), .start(start), .cont_mode(cont_mode),
    .range_mode(range_mode), .meter_freq(meter_freq), .meter_valid(meter_valid),
    .gate_clk(gate_clk), .busy(busy), .dbg_state(dbg_state), .res(r_if.master)
  );

  // ---------------- clock / reset ----------------
  always #50 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(100ns * 200000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0, n_pass = 0;
  int model_range = 0;
  logic [34:0] exp_q[$];   // {err, range, freq}

  function automatic int gate_len(int r);
    return (r == 0) ? G0 : ((r == 1) ? G1 : G2);
  endfunction

  function automatic logic [31:0] scale_sat(logic [31:0] c, int r);
    longint p;
    p = longint'({32'd0, c}) * ((r == 0) ? 1 : ((r == 1) ? 10 : 100));
    return (p > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(p);
  endfunction

  function automatic int next_range(int r, logic [31:0] c, bit err);
    if (err) return r;
    if (c >= 32'(RUP)) return (r < 2) ? r + 1 : r;
    if (c < 32'(RDN)) return (r > 0) ? r - 1 : r;
    return r;
  endfunction

  // ---------------- meter model / drivers ----------------
  bit mv_raised, mv_dropped;
  int mv_tv, mv_hold, t_drop;

  task automatic mv_tick();
    if (mv_raised && !mv_dropped && (cyc - mv_tv >= mv_hold)) begin
      meter_valid = 1'b0;
      mv_dropped  = 1'b1;
      t_drop      = cyc;
    end
  endtask

  // One measurement: optional start, waits for both gate edges, answers as
  // the meter would (resp_delay < 0 = never answers), then accepts the result
  // after ready_delay cycles of back-pressure. Returns observations only.
  task automatic drive_measurement(
    input bit do_start, input logic [31:0] cnt, input int resp_delay,
    input int hold, input int ready_delay,
    output int a_lat, output int spacing, output int b_to_res, output int cap_lat,
    output logic [31:0] f, output logic [1:0] r, output logic e,
    output int unstable, output bit ok);
    int t0, ta, tb, tr, n;
    ok = 1'b1; unstable = 0; a_lat = 0; spacing = 0; b_to_res = 0; cap_lat = 0;
    f = '0; r = '0; e = 1'b0;
    mv_raised = 1'b0; mv_dropped = 1'b0; mv_hold = hold; mv_tv = 0;
    t0 = cyc;
    if (do_start) begin
      start = 1'b1; @(negedge clk); start = 1'b0;
    end
    n = 0;
    while (gate_clk !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    if (gate_clk !== 1'b1) begin ok = 1'b0; return; end
    ta = cyc; a_lat = ta - t0;
    n = 0;
    while (gate_clk === 1'b1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (gate_clk !== 1'b1 && n < G0 + 100) begin @(negedge clk); n++; end
    if (gate_clk !== 1'b1) begin ok = 1'b0; return; end
    tb = cyc; spacing = tb - ta;
    if (resp_delay >= 0) begin
      repeat (resp_delay) @(negedge clk);
      meter_freq = cnt; meter_valid = 1'b1; mv_raised = 1'b1; mv_tv = cyc;
    end
    n = 0;
    while (r_if.res_valid !== 1'b1 && n < TMO + 200) begin
      @(negedge clk); n++; mv_tick();
    end
    if (r_if.res_valid !== 1'b1) begin meter_valid = 1'b0; ok = 1'b0; return; end
    tr = cyc; b_to_res = tr - tb; cap_lat = tr - mv_tv;
    f = r_if.res_freq; r = r_if.res_range; e = r_if.res_err;
    repeat (ready_delay) begin
      @(negedge clk); mv_tick();
      if (r_if.res_valid !== 1'b1 || r_if.res_freq !== f || r_if.res_range !== r ||
          r_if.res_err !== e || gate_clk !== 1'b0) unstable++;
    end
    r_if.res_ready = 1'b1;
    @(negedge clk);
    r_if.res_ready = 1'b0;
    mv_tick();
    while (mv_raised && !mv_dropped) begin @(negedge clk); mv_tick(); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cont_mode = 1'b0; range_mode = 2'd0;
    meter_freq = '0; meter_valid = 1'b0; r_if.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (gate_clk !== 1'b0) $display("FAIL reset_gate_clk: got %b want 0", gate_clk); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (r_if.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", r_if.res_valid); else n_pass++;
    n_checks++; if (r_if.res_freq !== 32'd0) $display("FAIL reset_res_freq: got %0d want 0", r_if.res_freq); else n_pass++;
    n_checks++; if (r_if.res_range !== 2'd0) $display("FAIL reset_res_range: got %0d want 0", r_if.res_range); else n_pass++;
    n_checks++; if (r_if.res_err !== 1'b0) $display("FAIL reset_res_err: got %b want 0", r_if.res_err); else n_pass++;
    model_range = 0;
  endtask

  task automatic test_fixed_ranges();
    int a_lat, sp, b2r, cap, unst; logic [31:0] f, cnt; logic [1:0] r; logic e; bit ok;
    logic [34:0] ev;
    cont_mode = 1'b0;
    for (int rg = 0; rg < 3; rg++) begin
      range_mode = 2'(rg);
      model_range = rg;
      cnt = $urandom_range(1, 40_000_000);
      exp_q.push_back({1'b0, 2'(rg), scale_sat(cnt, rg)});
      drive_measurement(1'b1, cnt, $urandom_range(20, 60), 20, 0, a_lat, sp, b2r, cap, f, r, e, unst, ok);
      ev = exp_q.pop_front();
      n_checks++; if (!ok) $display("FAIL fixed_done r%0d: measurement did not complete", rg); else n_pass++;
      n_checks++; if (a_lat != 9) $display("FAIL fixed_start_lat r%0d: got %0d want 9", rg, a_lat); else n_pass++;
      n_checks++; if (sp != gate_len(rg)) $display("FAIL fixed_spacing r%0d: got %0d want %0d", rg, sp, gate_len(rg)); else n_pass++;
      n_checks++; if (cap != 1) $display("FAIL fixed_capture_lat r%0d: got %0d want 1", rg, cap); else n_pass++;
      n_checks++; if (f !== ev[31:0]) $display("FAIL fixed_freq r%0d: got %0d want %0d", rg, f, ev[31:0]); else n_pass++;
      n_checks++; if (r !== ev[33:32]) $display("FAIL fixed_range r%0d: got %0d want %0d", rg, r, ev[33:32]); else n_pass++;
      n_checks++; if (e !== ev[34]) $display("FAIL fixed_err r%0d: got %b want %b", rg, e, ev[34]); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL fixed_idle r%0d: busy %b want 0", rg, busy); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int a_lat, sp, b2r, cap, unst; logic [31:0] f, cnt; logic [1:0] r; logic e; bit ok;
    int held;
    range_mode = 2'd3; cont_mode = 1'b0;
    held = model_range;
    drive_measurement(1'b1, 32'd0, -1, 0, 0, a_lat, sp, b2r, cap, f, r, e, unst, ok);
    n_checks++; if (!ok) $display("FAIL timeout_done: no result"); else n_pass++;
    n_checks++; if (b2r != TMO) $display("FAIL timeout_latency: got %0d want %0d", b2r, TMO); else n_pass++;
    n_checks++; if (e !== 1'b1) $display("FAIL timeout_err: got %b want 1", e); else n_pass++;
    n_checks++; if (f !== 32'd0) $display("FAIL timeout_freq: got %0d want 0", f); else n_pass++;
    n_checks++; if (r !== 2'(held)) $display("FAIL timeout_range: got %0d want %0d", r, held); else n_pass++;
    model_range = next_range(model_range, 32'd0, 1'b1);
    cnt = $urandom_range(0, RDN - 1);
    drive_measurement(1'b1, cnt, 30, 20, 0, a_lat, sp, b2r, cap, f, r, e, unst, ok);
    n_checks++; if (sp != gate_len(held)) $display("FAIL timeout_range_kept: spacing %0d want %0d", sp, gate_len(held)); else n_pass++;
    n_checks++; if (f !== scale_sat(cnt, held)) $display("FAIL timeout_next_freq: got %0d want %0d", f, scale_sat(cnt, held)); else n_pass++;
    model_range = next_range(model_range, cnt, 1'b0);
  endtask

  task automatic test_auto_cont();
    int a_lat, sp, b2r, cap, unst; logic [31:0] f, cnt; logic [1:0] r; logic e; bit ok;
    int exp_sp; logic [34:0] ev;
    range_mode = 2'd3; cont_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0, 1, 2: cnt = $urandom_range(RUP, RUP * 50);
        3:       cnt = $urandom_range(RDN, RUP - 1);
        4, 5, 6: cnt = $urandom_range(0, RDN - 1);
        7:       cnt = RUP;
        8:       cnt = RDN;
        default: cnt = RDN - 1;
      endcase
      if (i == 9) cont_mode = 1'b0;
      exp_sp = gate_len(model_range);
      exp_q.push_back({1'b0, 2'(model_range), scale_sat(cnt, model_range)});
      drive_measurement(i == 0, cnt, $urandom_range(20, 40), 20, 0, a_lat, sp, b2r, cap, f, r, e, unst, ok);
      ev = exp_q.pop_front();
      n_checks++; if (!ok) $display("FAIL auto_done #%0d: measurement did not complete", i); else n_pass++;
      n_checks++; if (sp != exp_sp) $display("FAIL auto_spacing #%0d: got %0d want %0d", i, sp, exp_sp); else n_pass++;
      n_checks++; if (r !== ev[33:32]) $display("FAIL auto_range #%0d: got %0d want %0d", i, r, ev[33:32]); else n_pass++;
      n_checks++; if (f !== ev[31:0]) $display("FAIL auto_freq #%0d: got %0d want %0d", i, f, ev[31:0]); else n_pass++;
      n_checks++; if (e !== ev[34]) $display("FAIL auto_err #%0d: got %b want %b", i, e, ev[34]); else n_pass++;
      model_range = next_range(model_range, cnt, 1'b0);
    end
    repeat (20) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL auto_stop: busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_saturation();
    int a_lat, sp, b2r, cap, unst; logic [31:0] f; logic [1:0] r; logic e; bit ok;
    logic [31:0] cnts [3];
    cnts[0] = 32'd50_000_000; cnts[1] = 32'd42_949_672; cnts[2] = 32'd42_949_673;
    range_mode = 2'd2; cont_mode = 1'b0; model_range = 2;
    for (int i = 0; i < 3; i++) begin
      drive_measurement(1'b1, cnts[i], 25, 20, 0, a_lat, sp, b2r, cap, f, r, e, unst, ok);
      n_checks++; if (f !== scale_sat(cnts[i], 2)) $display("FAIL sat_freq #%0d: got %h want %h", i, f, scale_sat(cnts[i], 2)); else n_pass++;
      n_checks++; if (e !== 1'b0 || r !== 2'd2) $display("FAIL sat_err_range #%0d: got err %b range %0d want 0/2", i, e, r); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_gate();
    int a_lat, sp, b2r, cap, unst, n; logic [31:0] f, cnt; logic [1:0] r; logic e; bit ok;
    range_mode = 2'd2; cont_mode = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (gate_clk !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    repeat (100) @(negedge clk);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    n_checks++; if (gate_clk !== 1'b0) $display("FAIL rstmid_gate_clk: got %b want 0", gate_clk); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (r_if.res_valid !== 1'b0) $display("FAIL rstmid_res_valid: got %b want 0", r_if.res_valid); else n_pass++;
    model_range = 0;
    range_mode = 2'd3;
    cnt = $urandom_range(RDN, RUP - 1);
    drive_measurement(1'b1, cnt, 30, 20, 0, a_lat, sp, b2r, cap, f, r, e, unst, ok);
    n_checks++; if (sp != G0) $display("FAIL rstmid_full_gate: spacing %0d want %0d", sp, G0); else n_pass++;
    n_checks++; if (r !== 2'd0 || f !== cnt) $display("FAIL rstmid_result: got %0d@r%0d want %0d@r0", f, r, cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    int a_lat, sp, b2r, cap, unst, extra; logic [31:0] f, cnt; logic [1:0] r; logic e; bit ok;
    range_mode = 2'd0; cont_mode = 1'b0; model_range = 0;
    cnt = $urandom_range(1, 1_000_000);
    drive_measurement(1'b1, cnt, 30, 20, 1000, a_lat, sp, b2r, cap, f, r, e, unst, ok);
    n_checks++; if (unst != 0) $display("FAIL bp_stable: %0d unstable cycles want 0", unst); else n_pass++;
    n_checks++; if (f !== cnt) $display("FAIL bp_freq: got %0d want %0d", f, cnt); else n_pass++;
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (r_if.res_valid !== 1'b0 || gate_clk !== 1'b0 || busy !== 1'b0) extra++;
    end
    n_checks++; if (extra != 0) $display("FAIL bp_single_handshake: %0d active cycles want 0", extra); else n_pass++;
  endtask

  task automatic test_lockout();
    int a_lat, sp, b2r, cap, unst; logic [31:0] f, cnt; logic [1:0] r; logic e; bit ok;
    range_mode = 2'd2; cont_mode = 1'b1; model_range = 2;
    cnt = $urandom_range(1, 10_000);
    drive_measurement(1'b1, cnt, 25, 60, 0, a_lat, sp, b2r, cap, f, r, e, unst, ok);
    n_checks++; if (f !== scale_sat(cnt, 2)) $display("FAIL lock_first_freq: got %0d want %0d", f, scale_sat(cnt, 2)); else n_pass++;
    cont_mode = 1'b0;
    cnt = $urandom_range(1, 10_000);
    drive_measurement(1'b0, cnt, 25, 20, 0, a_lat, sp, b2r, cap, f, r, e, unst, ok);
    n_checks++; if (a_lat != 8) $display("FAIL lock_quiet_cycles: A edge %0d cycles after meter_valid fell, want 8", a_lat); else n_pass++;
    n_checks++; if (f !== scale_sat(cnt, 2) || sp != G2) $display("FAIL lock_second: got %0d spacing %0d want %0d spacing %0d", f, sp, scale_sat(cnt, 2), G2); else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL lock_stop: busy %b want 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fixed_ranges();
    test_timeout();
    test_auto_cont();
    test_saturation();
    test_reset_mid_gate();
    test_backpressure();
    test_lockout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
